usb_tx_encoder: RTL and testbench

USB full-speed packet transmitter. It is the transmit-side counterpart of the receiver's PID/data FIFO path.
- On a start request it serialises SYNC, the PID byte and, for data PIDs, payload bytes drained from a first-word-fall-through byte FIFO.
- The serial stream is bit-stuffed and NRZI-encoded onto d_plus/d_minus, then closed with EOP.
- Sits between the transmit data FIFO and the bus driver.

---
 rtl/usb_tx_encoder_if.sv | 22 ++
 rtl/usb_tx_encoder.sv | 188 ++++++++++++++++++
 tb/tb_usb_tx_encoder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/usb_tx_encoder_if.sv
// rtl/usb_tx_encoder_if.sv - request, FIFO and bus-line signals of the USB transmit encoder
interface usb_tx_encoder_if;
  logic       tx_start;
  logic [3:0] tx_pid;
  logic [7:0] fifo_rdata;
  logic       fifo_empty;
  logic       fifo_renable;
  logic       d_plus;
  logic       d_minus;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_start, tx_pid, fifo_rdata, fifo_empty,
    input  fifo_renable, d_plus, d_minus, tx_busy, tx_done
  );

  modport slave (
    input  tx_start, tx_pid, fifo_rdata, fifo_empty,
    output fifo_renable, d_plus, d_minus, tx_busy, tx_done
  );
endinterface

// File: rtl/usb_tx_encoder.sv
// rtl/usb_tx_encoder.sv - USB full-speed packet transmitter: SYNC/PID/DATA, bit stuffing, NRZI, EOP
// Define USB_TX_CRC16_EN to append CRC16 to data packets.
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_BYTES    = 64
) (
  input  logic            clk,
  input  logic            n_rst,
  usb_tx_encoder_if.slave bus
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(MAX_BYTES + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMR_DONE = TW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] BYTE_MAX = BW'(MAX_BYTES);

  typedef enum logic [2:0] {
    IDLE, SYNC, PID, DATA,
`ifdef USB_TX_CRC16_EN
    CRC,
`endif
    EOP_SE0, EOP_J
  } state_t;

  state_t        state;
  logic [TW-1:0] tmr;
  logic [3:0]    bit_cnt;
  logic [14:0]   shreg;     // bits of the current field still to be sent, next one in [0]
  logic [2:0]    ones;
  logic          line;      // NRZI level, 1 = J
  logic [3:0]    pid;
  logic [BW-1:0] byte_cnt;
`ifdef USB_TX_CRC16_EN
  logic [15:0]   crc;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction
`endif

  state_t        adv_state;
  logic [3:0]    adv_cnt;
  logic [14:0]   adv_shreg;
  logic          adv_raw;
  logic          pop;
  logic          byte_end;
  logic          nrz_line;

  // Next raw bit after the one on the line; only used at a non-stuff bit boundary.
  always_comb begin
    adv_state = state;
    adv_cnt   = bit_cnt + 4'd1;
    adv_shreg = {1'b0, shreg[14:1]};
    adv_raw   = shreg[0];
    pop       = 1'b0;
    byte_end  = 1'b0;
    case (state)
      SYNC: if (bit_cnt == 4'd7) begin
        adv_state = PID;
        adv_cnt   = 4'd0;
        adv_shreg = {8'h00, ~pid, pid[3:1]};
        adv_raw   = pid[0];
      end
      PID: if (bit_cnt == 4'd7) begin
        if (pid[1:0] == 2'b11) byte_end = 1'b1;
        else begin
          adv_state = EOP_SE0;
          adv_cnt   = 4'd0;
        end
      end
      DATA: if (bit_cnt == 4'd7) byte_end = 1'b1;
`ifdef USB_TX_CRC16_EN
      CRC: if (bit_cnt == 4'd15) begin
        adv_state = EOP_SE0;
        adv_cnt   = 4'd0;
      end
`endif
      EOP_SE0: if (bit_cnt == 4'd1) adv_state = EOP_J;
      EOP_J: adv_state = IDLE;
      default: ;
    endcase
    if (byte_end) begin
      adv_cnt = 4'd0;
      if (!bus.fifo_empty && byte_cnt < BYTE_MAX) begin
        adv_state = DATA;
        adv_shreg = {8'h00, bus.fifo_rdata[7:1]};
        adv_raw   = bus.fifo_rdata[0];
        pop       = 1'b1;
      end else begin
`ifdef USB_TX_CRC16_EN
        adv_state = CRC;
        adv_shreg = ~crc[15:1];
        adv_raw   = ~crc[0];
`else
        adv_state = EOP_SE0;
`endif
      end
    end
    nrz_line = adv_raw ? line : ~line;
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state            <= IDLE;
      tmr              <= '0;
      bit_cnt          <= '0;
      shreg            <= '0;
      ones             <= '0;
      line             <= 1'b1;
      pid              <= '0;
      byte_cnt         <= '0;
      bus.d_plus       <= 1'b1;
      bus.d_minus      <= 1'b0;
      bus.tx_busy      <= 1'b0;
      bus.tx_done      <= 1'b0;
      bus.fifo_renable <= 1'b0;
`ifdef USB_TX_CRC16_EN
      crc              <= '0;
`endif
    end else begin
      bus.fifo_renable <= 1'b0;
      bus.tx_done      <= (state == EOP_J) && (tmr == TMR_DONE);
      if (state == IDLE) begin
        if (bus.tx_start) begin
          state       <= SYNC;
          tmr         <= '0;
          bit_cnt     <= '0;
          shreg       <= 15'h0040;
          ones        <= '0;
          pid         <= bus.tx_pid;
          byte_cnt    <= '0;
          line        <= 1'b0;
          bus.d_plus  <= 1'b0;
          bus.d_minus <= 1'b1;
          bus.tx_busy <= 1'b1;
`ifdef USB_TX_CRC16_EN
          crc         <= 16'hFFFF;
`endif
        end
      end else if (tmr != TMR_LAST) begin
        tmr <= tmr + TW'(1);
      end else begin
        tmr <= '0;
        if (ones == 3'd6) begin
          // stuffed zero: toggle, field position unchanged
          line        <= ~line;
          bus.d_plus  <= ~line;
          bus.d_minus <= line;
          ones        <= '0;
        end else begin
          state   <= adv_state;
          bit_cnt <= adv_cnt;
          shreg   <= adv_shreg;
          if (pop) begin
            bus.fifo_renable <= 1'b1;
            byte_cnt         <= byte_cnt + BW'(1);
`ifdef USB_TX_CRC16_EN
            crc              <= crc_byte(crc, bus.fifo_rdata);
`endif
          end
          case (adv_state)
            EOP_SE0: begin
              bus.d_plus  <= 1'b0;
              bus.d_minus <= 1'b0;
              ones        <= '0;
            end
            EOP_J: begin
              bus.d_plus  <= 1'b1;
              bus.d_minus <= 1'b0;
              line        <= 1'b1;
            end
            IDLE: bus.tx_busy <= 1'b0;
            default: begin
              line        <= nrz_line;
              bus.d_plus  <= nrz_line;
              bus.d_minus <= ~nrz_line;
              ones        <= adv_raw ? ones + 3'd1 : 3'd0;
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb/tb_usb_tx_encoder.sv - self-checking bench for usb_tx_encoder against a bit-list packet model
module tb_usb_tx_encoder;
  localparam int CPB  = 8;
  localparam int MAXB = 64;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  usb_tx_encoder_if bus();

  usb_tx_encoder #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct packed {logic dp; logic dm; logic busy; logic done;} exp_t;
  exp_t       expq[$];
  exp_t       e;
  logic [7:0] fifo[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         renable_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  task automatic refresh();
    bus.fifo_empty = (fifo.size() == 0);
    bus.fifo_rdata = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    refresh();
  endtask

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input bit b);
    return (c[0] ^ b) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
  endfunction

  // Packet model: raw bit list -> stuffed list -> NRZI levels -> per-cycle expectations.
  task automatic build(input logic [3:0] pid, output int nbits, output int npop);
    bit         raw[$];
    bit         st[$];
    logic [1:0] lines[$];
    logic       l;
    int         ones;
    logic [7:0] b;
    for (int i = 0; i < 8; i++) raw.push_back(i == 7);
    for (int i = 0; i < 4; i++) raw.push_back(pid[i]);
    for (int i = 0; i < 4; i++) raw.push_back(~pid[i]);
    npop = 0;
    if (pid[1:0] == 2'b11) begin
      npop = (fifo.size() < MAXB) ? fifo.size() : MAXB;
      for (int k = 0; k < npop; k++) begin
        b = fifo[k];
        for (int i = 0; i < 8; i++) raw.push_back(b[i]);
      end
`ifdef USB_TX_CRC16_EN
      begin
        logic [15:0] c;
        c = 16'hFFFF;
        for (int k = 0; k < npop; k++) begin
          b = fifo[k];
          for (int i = 0; i < 8; i++) c = crc_bit(c, b[i]);
        end
        for (int i = 0; i < 16; i++) raw.push_back(~c[i]);
      end
`endif
    end
    ones = 0;
    foreach (raw[i]) begin
      st.push_back(raw[i]);
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 6) begin
        st.push_back(1'b0);
        ones = 0;
      end
    end
    l = 1'b1;
    foreach (st[i]) begin
      if (!st[i]) l = ~l;
      lines.push_back({l, ~l});
    end
    lines.push_back(2'b00);
    lines.push_back(2'b00);
    lines.push_back(2'b10);
    nbits = lines.size();
    expq.delete();
    expq.push_back(4'b1000);
    foreach (lines[i])
      for (int j = 0; j < CPB; j++)
        expq.push_back({lines[i], 1'b1, (i == lines.size() - 1) && (j == CPB - 1)});
    expq.push_back(4'b1000);
  endtask

  // Every cycle the model has an expectation for, compare the line and handshake outputs.
  always @(negedge clk) begin
    if (bus.fifo_renable) begin
      check("renable_while_empty", {31'd0, bus.fifo_empty}, 32'd0);
      renable_seen++;
      if (fifo.size() > 0) void'(fifo.pop_front());
      refresh();
    end
    if (!n_rst && expq.size() > 0) begin
      e = expq.pop_front();
      check("line_busy_done", {28'd0, bus.d_plus, bus.d_minus, bus.tx_busy, bus.tx_done}, {28'd0, e});
    end
  end

  task automatic send(input logic [3:0] pid, input int poke, input int abort, output int nbits);
    int p0;
    int npop;
    @(posedge clk); #1;
    p0 = renable_seen;
    build(pid, nbits, npop);
    bus.tx_pid   = pid;
    bus.tx_start = 1'b1;
    @(posedge clk); #1 bus.tx_start = 1'b0;
    if (poke > 0) begin
      repeat (poke) @(posedge clk);
      #1 bus.tx_start = 1'b1;
      bus.tx_pid = 4'b0011;
      @(posedge clk); #1 bus.tx_start = 1'b0;
      bus.tx_pid = pid;
    end
    if (abort > 0) begin
      repeat (abort) @(posedge clk);
      #3;
      expq.delete();
      n_rst = 1'b1;
      #1;
      check("rst_d_plus", {31'd0, bus.d_plus}, 32'd1);
      check("rst_d_minus", {31'd0, bus.d_minus}, 32'd0);
      check("rst_tx_busy", {31'd0, bus.tx_busy}, 32'd0);
      check("rst_tx_done", {31'd0, bus.tx_done}, 32'd0);
      check("rst_renable", {31'd0, bus.fifo_renable}, 32'd0);
      repeat (3) @(posedge clk);
      #1 n_rst = 1'b0;
    end else begin
      for (int i = 0; i < 10000 && expq.size() != 0; i++) @(posedge clk);
      check("drain_timeout", expq.size(), 32'd0);
      check("renable_count", renable_seen - p0, npop);
    end
  endtask

  initial begin
    int          nb;
    string       s;
    logic [7:0]  ch;
    logic [15:0] c;
    n_rst        = 1'b1;
    bus.tx_start = 1'b0;
    bus.tx_pid   = 4'h0;
    refresh();
    repeat (3) @(posedge clk);
    #1;
    check("reset_d_plus", {31'd0, bus.d_plus}, 32'd1);
    check("reset_d_minus", {31'd0, bus.d_minus}, 32'd0);
    check("reset_tx_busy", {31'd0, bus.tx_busy}, 32'd0);
    check("reset_tx_done", {31'd0, bus.tx_done}, 32'd0);
    check("reset_renable", {31'd0, bus.fifo_renable}, 32'd0);
    n_rst = 1'b0;

    s = "123456789";
    c = 16'hFFFF;
    for (int i = 0; i < 9; i++) begin
      ch = s[i];
      for (int j = 0; j < 8; j++) c = crc_bit(c, ch[j]);
    end
    check("pin_crc16_check", {16'd0, ~c}, 32'hB4C8);

    send(4'b0010, 0, 0, nb);
    check("pin_ack_bits", nb, 32'd19);

    push(8'hFF);
    send(4'b0011, 0, 0, nb);
    check("pin_data0_ff_bits", nb, 32'd28);

    send(4'b1011, 0, 0, nb);
`ifdef USB_TX_CRC16_EN
    check("pin_data1_empty_bits", nb, 32'd35);
`else
    check("pin_data1_empty_bits", nb, 32'd19);
`endif

    push(8'h00); push(8'h7E); push(8'hFF); push(8'hA5); push(8'h3F);
    send(4'b0011, 0, 0, nb);

    push(8'h11);
    send(4'b1010, 0, 0, nb);
    check("nak_fifo_untouched", fifo.size(), 32'd1);
    fifo.delete();
    refresh();

    for (int k = 0; k < 70; k++) push(8'(k * 37 + 1));
    send(4'b0011, 0, 0, nb);
    check("max_bytes_left", fifo.size(), 32'd6);
    check("max_fifo_empty", {31'd0, bus.fifo_empty}, 32'd0);
    fifo.delete();
    refresh();

    send(4'b0010, 40, 0, nb);
    check("poke_ack_bits", nb, 32'd19);

    push(8'hFF); push(8'h01); push(8'hC3); push(8'h80);
    send(4'b0011, 0, 200, nb);
    fifo.delete();
    refresh();
    send(4'b0010, 0, 0, nb);
    check("post_reset_ack_bits", nb, 32'd19);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
